// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC, next-PC selection, EPC capture,
// halt control and a circular return-address stack.
module pc_unit #(
  parameter int unsigned W         = 32,
  parameter logic [W-1:0] RESET_VEC = '0,
  parameter logic [W-1:0] EXC_VEC   = W'(32'h0000_0080),
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [W-1:0] branch_target,
  input  logic         jump,
  input  logic [W-1:0] jump_target,
  input  logic         call,
  input  logic         ret,
  input  logic         exc,
  input  logic         eret,
  input  logic         halt,
  input  logic         resume,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_plus4,
  output logic         pc_valid,
  output logic [W-1:0] epc,
  output logic         ras_empty,
  output logic         ras_underflow,
  output logic [1:0]   state
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  pc_q, pc_d;
  logic [W-1:0]  epc_q, epc_d;
  logic          uf_q, uf_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  ras_q [RAS_DEPTH];

  logic          ras_we;
  logic [PW-1:0] ras_waddr;
  logic [W-1:0]  ras_wdata;
  logic [W-1:0]  inc;
  logic [W-1:0]  top;
  logic [PW-1:0] ptr_m1;

  function automatic logic [W-1:0] align(input logic [W-1:0] t);
    return {t[W-1:2], 2'b00};
  endfunction

  assign inc    = pc_q + W'(4);
  assign ptr_m1 = ptr_q - 1'b1;
  assign top    = ras_q[ptr_m1];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    uf_d      = uf_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ras_we    = 1'b0;
    ras_waddr = ptr_q;
    ras_wdata = inc;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (exc) begin
          epc_d = pc_q;
          pc_d  = align(EXC_VEC);
        end else if (stall) begin
          pc_d = pc_q;
        end else if (halt) begin
          state_d = S_HALT;
        end else if (eret) begin
          pc_d = epc_q;
        end else if (ret) begin
          if (cnt_q != '0) begin
            pc_d = top;
            // A simultaneous jal swaps the popped entry for its own link.
            if (jump && call) begin
              ras_we    = 1'b1;
              ras_waddr = ptr_m1;
            end else begin
              ptr_d = ptr_m1;
              cnt_d = cnt_q - 1'b1;
            end
          end else begin
            pc_d = inc;
            uf_d = 1'b1;
          end
        end else if (jump) begin
          pc_d = align(jump_target);
          if (call) begin
            ras_we = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            cnt_d  = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
          end
        end else if (branch_taken) begin
          pc_d = align(branch_target);
        end else begin
          pc_d = inc;
        end
      end
      S_HALT: begin
        if (exc) begin
          epc_d   = pc_q;
          pc_d    = align(EXC_VEC);
          state_d = S_RUN;
        end else if (resume) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= align(RESET_VEC);
      epc_q   <= '0;
      uf_q    <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      uf_q    <= uf_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_waddr] <= ras_wdata;
  end

  assign pc            = pc_q;
  assign pc_plus4      = inc;
  assign pc_valid      = (state_q == S_RUN);
  assign epc           = epc_q;
  assign ras_empty     = (cnt_q == '0);
  assign ras_underflow = uf_q;
  assign state         = state_q;

endmodule
